// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 on load, per-round C/D rotation, PC-2 subkey
// presented one round at a time behind a valid/ready handshake.
module des_key_sched #(
    parameter bit KEY_PARITY_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic        parity_err
);
    // Tables use DES numbering: bit 1 is the MSB of the vector it selects from.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [27:0] c, d, c_n, d_n;
    logic        dir, dir_n;
    logic [3:0]  idx_n;
    logic        done_n, perr_n, perr_calc;
    logic [55:0] pc1_out;
    logic [55:0] cd;
    logic        xfer;

    function automatic logic [1:0] shamt(input logic [4:0] r);
        return (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    for (genvar j = 0; j < 56; j++) begin : g_pc1
        assign pc1_out[55-j] = key[64-PC1[j]];
    end

    assign cd = {c, d};
    for (genvar k = 0; k < 48; k++) begin : g_pc2
        assign subkey[47-k] = cd[56-PC2[k]];
    end

    always_comb begin
        perr_calc = 1'b0;
        for (int i = 0; i < 8; i++) perr_calc = perr_calc | ~^key[8*i +: 8];
    end

    assign subkey_valid = (state == RUN);
    assign busy         = (state == RUN);
    assign xfer         = subkey_valid & subkey_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            c          <= '0;
            d          <= '0;
            dir        <= 1'b0;
            round_idx  <= '0;
            done       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_n;
            c          <= c_n;
            d          <= d_n;
            dir        <= dir_n;
            round_idx  <= idx_n;
            done       <= done_n;
            parity_err <= perr_n;
        end
    end

    always_comb begin
        state_n = state;
        c_n     = c;
        d_n     = d;
        dir_n   = dir;
        idx_n   = round_idx;
        done_n  = 1'b0;
        perr_n  = parity_err;
        case (state)
            IDLE: begin
                if (start) begin
                    // Decrypt starts from C16/D16, which equals the unrotated PC-1 output.
                    c_n     = decrypt ? pc1_out[55:28] : rotl(pc1_out[55:28], 2'd1);
                    d_n     = decrypt ? pc1_out[27:0]  : rotl(pc1_out[27:0], 2'd1);
                    dir_n   = decrypt;
                    idx_n   = '0;
                    perr_n  = KEY_PARITY_CHECK ? perr_calc : 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (round_idx == 4'd15) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = round_idx + 4'd1;
                        if (dir) begin
                            c_n = rotr(c, shamt(5'd16 - {1'b0, round_idx}));
                            d_n = rotr(d, shamt(5'd16 - {1'b0, round_idx}));
                        end else begin
                            c_n = rotl(c, shamt({1'b0, round_idx} + 5'd2));
                            d_n = rotl(d, shamt({1'b0, round_idx} + 5'd2));
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_des_key_sched.sv
// Randomized bench for des_key_sched against a table-driven DES key schedule model.
module tb_des_key_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, decrypt, subkey_ready;
    logic [63:0] key;
    logic [47:0] subkey;
    logic        subkey_valid, busy, done, parity_err;
    logic [3:0]  round_idx;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] KAT_KEY   = 64'h133457799BBCDFF1;
    localparam logic [47:0] KAT_FIRST = 48'h1B02EFFC7072;
    localparam logic [47:0] KAT_LAST  = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    logic [47:0] exp_ks [16];
    logic        exp_perr;

    des_key_sched #(.KEY_PARITY_CHECK(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Subkey r uses C0/D0 rotated left by the cumulative shift count through round r.
    task automatic compute_model(input logic [63:0] k);
        bit kb [1:64];
        bit c0 [28];
        bit d0 [28];
        int tot, j;
        for (int i = 1; i <= 64; i++) kb[i] = k[64-i];
        for (int i = 0; i < 28; i++) begin
            c0[i] = kb[PC1_T[i]];
            d0[i] = kb[PC1_T[i+28]];
        end
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
            for (int b = 0; b < 48; b++) begin
                j = PC2_T[b];
                exp_ks[r][47-b] = (j <= 28) ? c0[(j - 1 + tot) % 28] : d0[(j - 29 + tot) % 28];
            end
        end
        exp_perr = 1'b0;
        for (int i = 0; i < 8; i++)
            if ($countones(k[8*i +: 8]) % 2 == 0) exp_perr = 1'b1;
    endtask

    // mode 0: ready=1, 1: random ready, 2: start injected mid-run, 3: reset at idx 7
    task automatic run(input logic [63:0] k, input bit dec, input int mode);
        int n, cyc;
        bit stalled, rdy;
        logic [47:0] prev_sk, exp_sk;
        logic [3:0] prev_idx;
        compute_model(k);
        @(negedge clk);
        start = 1'b1; key = k; decrypt = dec; subkey_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; key = {$urandom, $urandom}; decrypt = ~dec;
        chk("busy_after_start", busy, 1);
        chk("parity_err", parity_err, exp_perr);
        n = 0; cyc = 0; stalled = 1'b0; prev_sk = '0; prev_idx = '0;
        while (n < 16 && cyc < 400) begin
            chk("valid", subkey_valid, 1);
            chk("done_low", done, 0);
            if (stalled) begin
                chk("stall_subkey", subkey, prev_sk);
                chk("stall_idx", round_idx, prev_idx);
            end
            chk("round_idx", round_idx, n);
            exp_sk = dec ? exp_ks[15-n] : exp_ks[n];
            chk("subkey", subkey, exp_sk);
            if (k == KAT_KEY && n == 0)  chk("kat_first", subkey, dec ? KAT_LAST : KAT_FIRST);
            if (k == KAT_KEY && n == 15) chk("kat_last", subkey, dec ? KAT_FIRST : KAT_LAST);
            if (mode == 3 && n == 7) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", subkey_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_subkey", subkey, 0);
                chk("rst_idx", round_idx, 0);
                chk("rst_done", done, 0);
                chk("rst_perr", parity_err, 0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("rst_no_done", done, 0);
                    chk("rst_idle", busy, 0);
                end
                return;
            end
            rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2 && n == 3) begin
                start = 1'b1; key = ~k; decrypt = ~dec;
            end
            subkey_ready = rdy;
            stalled = !rdy;
            prev_sk = subkey;
            prev_idx = round_idx;
            if (rdy) n++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("sched_complete", n, 16);
        subkey_ready = 1'b0;
        if (mode != 1) chk("done_cycle", cyc, 16);
        chk("done_pulse", done, 1);
        chk("valid_after", subkey_valid, 0);
        chk("busy_after", busy, 0);
        chk("perr_held", parity_err, exp_perr);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("perr_held2", parity_err, exp_perr);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b0; key = '0;
        #1;
        chk("reset_valid", subkey_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_subkey", subkey, 0);
        chk("reset_idx", round_idx, 0);
        chk("reset_perr", parity_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(KAT_KEY, 1'b0, 0);
        run(KAT_KEY, 1'b1, 0);
        run(KAT_KEY, 1'b0, 1);
        run(64'h133457799BBCDFF0, 1'b0, 0);
        run(KAT_KEY, 1'b0, 2);
        run(KAT_KEY, 1'b0, 3);
        run(KAT_KEY, 1'b0, 0);
        for (int t = 0; t < 12; t++)
            run({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        run({$urandom, $urandom}, 1'b1, 3);
        run({$urandom, $urandom}, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
